// File: rtl/vga_sync_gen.sv
// VGA/HDMI-style raster timing generator.
// Free-running horizontal/vertical counters gated by a pixel-advance enable.
// All outputs are registered decodes of the pre-increment counter values.
// Sync polarity is selectable per axis.
module vga_sync_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        en,
   output logic [11:0] pixel_x,
   output logic [11:0] pixel_y,
   output logic        video_on,
   output logic        hsync,
   output logic        vsync,
   output logic        line_start,
   output logic        frame_start,
   output logic [15:0] frame_count
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Counters are 12 bits wide, so a raster larger than 4096 cannot be counted.
   // Zero-length timing intervals are rejected as configuration errors.
   // The polarity parameters are levels, so 0 is a legal value for them.
   if (H_TOTAL > 4096 || V_TOTAL > 4096) begin : g_bad_total
      $error("vga_sync_gen: H_TOTAL or V_TOTAL exceeds 4096");
   end
   if (H_ACTIVE == 0 || H_FP == 0 || H_SYNC == 0 || H_BP == 0 ||
       V_ACTIVE == 0 || V_FP == 0 || V_SYNC == 0 || V_BP == 0) begin : g_bad_zero
      $error("vga_sync_gen: timing parameters must be non-zero");
   end

   // 12-bit decode thresholds.
   localparam logic [11:0] H_ACT_W    = 12'(H_ACTIVE);
   localparam logic [11:0] H_SYNC_BEG = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_SYNC_END = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_W    = 12'(V_ACTIVE);
   localparam logic [11:0] V_SYNC_BEG = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_SYNC_END = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);

   logic [11:0] h_q, h_d;
   logic [11:0] v_q, v_d;
   logic [11:0] px_q, px_d;
   logic [11:0] py_q, py_d;
   logic        video_q, video_d;
   logic        hsync_q, hsync_d;
   logic        vsync_q, vsync_d;
   logic        line_q, line_d;
   logic        frame_q, frame_d;
   logic [15:0] fcount_q, fcount_d;
   logic        h_wrap;

   // Counter advance and registered decode of the current (pre-increment) position.
   always_comb begin
      h_wrap   = (h_q == H_LAST);
      h_d      = h_wrap ? 12'd0 : h_q + 12'd1;
      v_d      = v_q;
      if (h_wrap) begin
         v_d = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
      end
      px_d     = h_q;
      py_d     = v_q;
      video_d  = (h_q < H_ACT_W) && (v_q < V_ACT_W);
      hsync_d  = (h_q >= H_SYNC_BEG && h_q < H_SYNC_END) ? HS_POL : ~HS_POL;
      // vsync depends on v only, so its output changes together with pixel_x=0.
      vsync_d  = (v_q >= V_SYNC_BEG && v_q < V_SYNC_END) ? VS_POL : ~VS_POL;
      line_d   = (h_q == 12'd0);
      frame_d  = line_d && (v_q == 12'd0);
      fcount_d = frame_d ? fcount_q + 16'd1 : fcount_q;
   end

   // State and output registers; everything holds while en is low.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_q      <= 12'd0;
         v_q      <= 12'd0;
         px_q     <= 12'd0;
         py_q     <= 12'd0;
         video_q  <= 1'b0;
         hsync_q  <= ~HS_POL;
         vsync_q  <= ~VS_POL;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
         fcount_q <= 16'd0;
      end else if (en) begin
         h_q      <= h_d;
         v_q      <= v_d;
         px_q     <= px_d;
         py_q     <= py_d;
         video_q  <= video_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         line_q   <= line_d;
         frame_q  <= frame_d;
         fcount_q <= fcount_d;
      end
   end

   assign pixel_x     = px_q;
   assign pixel_y     = py_q;
   assign video_on    = video_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign line_start  = line_q;
   assign frame_start = frame_q;
   assign frame_count = fcount_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Self-checking bench for vga_sync_gen using a small raster (28 x 13).
// A reference model produces the expected output word for every cycle.
// Each expected word is queued as the stimulus is driven.
// It is popped and compared after the clock edge.
module tb_vga_sync_gen;

   localparam int HA = 16, HF = 4, HSW = 3, HB = 5;
   localparam int VA = 6,  VF = 2, VSW = 2, VB = 3;
   localparam int HT = HA + HF + HSW + HB;   // 28
   localparam int VT = VA + VF + VSW + VB;   // 13
   localparam bit HSP = 1'b1, VSP = 1'b1;
   localparam int W = 45;
   // Packed word: {px[44:33], py[32:21], von[20], hs[19], vs[18], ls[17], fs[16], fc[15:0]}
   localparam int B_VON = 20, B_HS = 19, B_VS = 18, B_LS = 17, B_FS = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en = 1'b0;
   logic [11:0] pixel_x, pixel_y;
   logic        video_on, hsync, vsync, line_start, frame_start;
   logic [15:0] frame_count;

   vga_sync_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
      .HS_POL(HSP), .VS_POL(VSP)
   ) dut (
      .clk(clk), .reset(reset), .en(en),
      .pixel_x(pixel_x), .pixel_y(pixel_y), .video_on(video_on),
      .hsync(hsync), .vsync(vsync), .line_start(line_start),
      .frame_start(frame_start), .frame_count(frame_count)
   );

   // Clock generation
   always #5 clk = ~clk;

   // Scoreboard state
   logic [W-1:0] exp_q[$];
   int           n_checks = 0;
   int           n_fail = 0;

   // Reference model state
   int           mh, mv;
   logic [15:0]  mfc;
   logic [W-1:0] last_exp;

   function automatic logic [W-1:0] obs();
      return {pixel_x, pixel_y, video_on, hsync, vsync, line_start, frame_start, frame_count};
   endfunction

   function automatic logic [W-1:0] reset_exp();
      return {12'd0, 12'd0, 1'b0, ~HSP, ~VSP, 1'b0, 1'b0, 16'd0};
   endfunction

   function automatic logic [W-1:0] pack_exp(int h, int v, logic [15:0] fc, logic ls, logic fs);
      logic von, hs, vs;
      von = (h < HA) && (v < VA);
      hs  = (h >= HA + HF && h < HA + HF + HSW) ? HSP : ~HSP;
      vs  = (v >= VA + VF && v < VA + VF + VSW) ? VSP : ~VSP;
      return {12'(h), 12'(v), von, hs, vs, ls, fs, fc};
   endfunction

   task automatic model_reset();
      mh = 0;
      mv = 0;
      mfc = 16'd0;
      last_exp = reset_exp();
   endtask

   // Driver: called at posedge+1; drives en, queues the expected word, and
   // returns at the next posedge+1, ready for sampling.
   task automatic drive_cycle(input logic en_v);
      logic         fs;
      logic [W-1:0] e;
      en = en_v;
      if (en_v) begin
         fs = (mh == 0) && (mv == 0);
         if (fs) mfc = mfc + 16'd1;
         e = pack_exp(mh, mv, mfc, mh == 0, fs);
         last_exp = e;
         mh++;
         if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
         end
      end else begin
         e = last_exp;
      end
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      logic [W-1:0] got, e;
      #1;
      exp_q.push_back(reset_exp());
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL reset_init: got %h exp %h", got, e); end
      en = 1'b1;
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back(reset_exp());
         @(posedge clk); #1;
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL reset_hold: got %h exp %h", got, e); end
      end
      en = 1'b0;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_first_edge(input string tag);
      logic [W-1:0] got, e;
      drive_cycle(1'b1);
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL %s: got %h exp %h", tag, got, e); end
      n_checks++;
      if (got[44:21] !== 24'd0 || got[B_VON] !== 1'b1 || got[B_LS] !== 1'b1 ||
          got[B_FS] !== 1'b1 || got[15:0] !== 16'd1) begin
         n_fail++;
         $display("FAIL %s_fields: got %h exp px=0 py=0 von=1 ls=1 fs=1 fc=1", tag, got);
      end
   endtask

   task automatic test_line();
      logic [W-1:0] got, e;
      int von_cnt, hs_cnt, ls_cnt;
      von_cnt = 0; hs_cnt = 0; ls_cnt = 0;
      for (int i = 1; i <= HT; i++) begin
         drive_cycle(1'b1);
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL line0 i=%0d: got %h exp %h", i, got, e); end
         if (i < HT && got[B_VON] === 1'b1) von_cnt++;
         if (got[B_HS] === HSP) hs_cnt++;
         if (got[B_LS] === 1'b1) ls_cnt++;
      end
      n_checks++;
      if (von_cnt !== HA - 1) begin n_fail++; $display("FAIL line0_video: got %0d exp %0d", von_cnt, HA - 1); end
      n_checks++;
      if (hs_cnt !== HSW) begin n_fail++; $display("FAIL line0_hsync: got %0d exp %0d", hs_cnt, HSW); end
      n_checks++;
      if (ls_cnt !== 1 || got[B_LS] !== 1'b1) begin
         n_fail++; $display("FAIL line_period: got count %0d last %b exp 1 and 1", ls_cnt, got[B_LS]);
      end
   endtask

   task automatic test_frame();
      logic [W-1:0] got, e;
      int vs_cnt, blank_von;
      vs_cnt = 0; blank_von = 0;
      for (int i = 0; i < HT * VT - HT; i++) begin
         drive_cycle(1'b1);
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL frame i=%0d: got %h exp %h", i, got, e); end
         if (got[B_VS] === VSP) vs_cnt++;
         if (got[32:21] >= 12'(VA) && got[B_VON] === 1'b1) blank_von++;
      end
      n_checks++;
      if (vs_cnt !== VSW * HT) begin n_fail++; $display("FAIL frame_vsync: got %0d exp %0d", vs_cnt, VSW * HT); end
      n_checks++;
      if (blank_von !== 0) begin n_fail++; $display("FAIL frame_vblank_video: got %0d exp 0", blank_von); end
      n_checks++;
      if (got[44:21] !== 24'd0 || got[B_FS] !== 1'b1 || got[15:0] !== 16'd2) begin
         n_fail++; $display("FAIL frame_wrap: got %h exp px=0 py=0 fs=1 fc=2", got);
      end
   endtask

   task automatic test_en_hold();
      logic [W-1:0] got, e;
      int pulses;
      // Advance to pixel_x=10.
      for (int i = 0; i < HT && last_exp[44:33] != 12'd10; i++) begin
         drive_cycle(1'b1);
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL hold_seek: got %h exp %h", got, e); end
      end
      pulses = 0;
      for (int i = 0; i < 7; i++) begin
         drive_cycle(1'b0);
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL hold_mid i=%0d: got %h exp %h", i, got, e); end
         if (got[B_LS] === 1'b1 || got[B_FS] === 1'b1) pulses++;
      end
      n_checks++;
      if (pulses !== 0) begin n_fail++; $display("FAIL hold_pulses: got %0d exp 0", pulses); end
      drive_cycle(1'b1);
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e || got[44:33] !== 12'd11) begin
         n_fail++; $display("FAIL hold_resume: got %h exp %h", got, e);
      end
      // Hold on a line start: the pulse stretches.
      for (int i = 0; i < HT && last_exp[44:33] != 12'd0; i++) begin
         drive_cycle(1'b1);
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL hold_seek0: got %h exp %h", got, e); end
      end
      for (int i = 0; i < 5; i++) begin
         drive_cycle(1'b0);
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e || got[B_LS] !== 1'b1) begin
            n_fail++; $display("FAIL hold_stretch i=%0d: got %h exp %h", i, got, e);
         end
      end
      drive_cycle(1'b1);
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e || got[44:33] !== 12'd1 || got[B_LS] !== 1'b0) begin
         n_fail++; $display("FAIL hold_stretch_end: got %h exp %h", got, e);
      end
   endtask

   task automatic test_random_en();
      logic [W-1:0] got, e;
      for (int i = 0; i < 3 * HT * VT; i++) begin
         drive_cycle(($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL random_en i=%0d: got %h exp %h", i, got, e); end
      end
   endtask

   task automatic test_async_reset();
      logic [W-1:0] got, e;
      for (int i = 0; i < HT * VT + HT &&
           !(last_exp[44:33] == 12'd12 && last_exp[32:21] == 12'd4); i++) begin
         drive_cycle(1'b1);
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL async_seek: got %h exp %h", got, e); end
      end
      n_checks++;
      if (pixel_x !== 12'd12 || pixel_y !== 12'd4) begin
         n_fail++; $display("FAIL async_position: got (%0d,%0d) exp (12,4)", pixel_x, pixel_y);
      end
      #2;
      reset = 1'b1;
      #1;
      exp_q.push_back(reset_exp());
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL async_reset: got %h exp %h", got, e); end
      exp_q.push_back(reset_exp());
      @(posedge clk); #1;
      e = exp_q.pop_front(); got = obs(); n_checks++;
      if (got !== e) begin n_fail++; $display("FAIL async_reset_hold: got %h exp %h", got, e); end
      reset = 1'b0;
      model_reset();
      test_first_edge("async_restart");
   endtask

   task automatic test_count_wrap();
      logic [W-1:0] got, e;
      bit seen;
      force dut.fcount_q = 16'hFFFF;
      #1;
      release dut.fcount_q;
      mfc = 16'hFFFF;
      last_exp[15:0] = 16'hFFFF;
      seen = 1'b0;
      for (int i = 0; i < HT * VT + 2 && !seen; i++) begin
         drive_cycle(1'b1);
         e = exp_q.pop_front(); got = obs(); n_checks++;
         if (got !== e) begin n_fail++; $display("FAIL count_wrap_run i=%0d: got %h exp %h", i, got, e); end
         if (got[B_FS] === 1'b1) begin
            seen = 1'b1;
            n_checks++;
            if (got[15:0] !== 16'h0000) begin
               n_fail++; $display("FAIL count_wrap: got %h exp 0000", got[15:0]);
            end
         end
      end
      if (!seen) begin
         n_checks++; n_fail++;
         $display("FAIL count_wrap_timeout: got no frame_start exp one within %0d cycles", HT * VT + 2);
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_first_edge("first_edge");
      test_line();
      test_frame();
      test_en_hold();
      test_random_en();
      test_async_reset();
      test_count_wrap();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Watchdog
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout exp completion");
      $fatal(1, "watchdog expired");
   end

endmodule
